// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_if
//  Description : Operation request / result bundle between the execute-stage
//                ALU (slave) and the issuing pipeline logic (master).
//                Request : start, ALUCtrl, A, B, shamt
//                Response: result, zero, hi, lo, busy, done, div_by_zero
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUCtrl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, ALUCtrl, A, B, shamt,
        input  result, zero, hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, ALUCtrl, A, B, shamt,
        output result, zero, hi, lo, busy, done, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec
//  Description : Execute-stage ALU. Single-cycle logic/arith/compare/shift
//                ops plus optional iterative signed mult/div (1 bit/cycle)
//                that stall the pipeline through `busy`.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - alu_exec_if.slave (request in, registered results out)
//  Config      : ALU_MULDIV_EN - when defined, builds the mult/div datapath
//                and the MUL/DIV/FIX states; otherwise codes 7/8 behave as
//                illegal codes and hi/lo/busy/div_by_zero are tied low.
//  Parameters  : WIDTH - operand/result width, must be >= 2
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);
    localparam int c_SHW = $clog2(WIDTH);
    localparam int c_SHU = (c_SHW < 5) ? c_SHW : 5;   // usable shamt bits

    logic [c_SHU-1:0] w_shamt;
    logic [WIDTH-1:0] w_alu;

    assign w_shamt = bus.shamt[c_SHU-1:0];

    // Single-cycle result; codes 7/8 fall to zero here and are overridden
    // by the mult/div path when it is built.
    always_comb begin
        w_alu = '0;
        case (bus.ALUCtrl)
            4'd0:    w_alu = bus.A & bus.B;
            4'd1:    w_alu = bus.A | bus.B;
            4'd2:    w_alu = bus.A + bus.B;
            4'd3:    w_alu = bus.A - bus.B;
            4'd4:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            4'd5:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.A) > $signed(bus.B))};
            4'd6:    w_alu = ~bus.A;
            4'd9:    w_alu = bus.B << w_shamt;
            4'd10:   w_alu = bus.B >> w_shamt;
            default: w_alu = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int c_CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           r_state;
    logic [c_CW-1:0]  r_cnt;
    logic             r_is_div;
    logic             r_neg_q;      // product / quotient sign
    logic             r_neg_r;      // remainder sign (dividend sign)
    logic [WIDTH-1:0] r_acc_hi;     // mult: partial product high / div: remainder
    logic [WIDTH-1:0] r_acc_lo;     // mult: multiplier->product low / div: dividend->quotient
    logic [WIDTH-1:0] r_opb;        // mult: multiplicand / div: divisor
    logic [WIDTH-1:0] r_result, r_hi, r_lo;
    logic             r_zero, r_busy, r_done, r_dbz;

    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH-1:0]   w_ddiff;
    logic               w_dge;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

    assign w_mag_a = bus.A[WIDTH-1] ? ({WIDTH{1'b0}} - bus.A) : bus.A;
    assign w_mag_b = bus.B[WIDTH-1] ? ({WIDTH{1'b0}} - bus.B) : bus.B;

    // Shift-add step: add multiplicand when the current multiplier bit is
    // set, then shift the whole {carry, hi, lo} right by one.
    assign w_msum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    assign w_dshift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_dge    = (w_dshift >= {1'b0, r_opb});
    assign w_ddiff  = w_dshift[WIDTH-1:0] - r_opb;

    assign w_prod   = {r_acc_hi, r_acc_lo};
    assign w_prod_s = r_neg_q ? ({(2*WIDTH){1'b0}} - w_prod) : w_prod;

    always_comb begin
        w_fix_hi = w_prod_s[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_s[WIDTH-1:0];
        if (r_is_div) begin
            // most-negative / -1 wraps back to most-negative here
            w_fix_lo = r_neg_q ? ({WIDTH{1'b0}} - r_acc_lo) : r_acc_lo;
            w_fix_hi = r_neg_r ? ({WIDTH{1'b0}} - r_acc_hi) : r_acc_hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dbz <= 1'b0;
                        if (bus.ALUCtrl == 4'd7 || (bus.ALUCtrl == 4'd8 && bus.B != '0)) begin
                            r_is_div <= (bus.ALUCtrl == 4'd8);
                            r_neg_q  <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                            r_neg_r  <= bus.A[WIDTH-1];
                            r_acc_hi <= '0;
                            r_cnt    <= c_CW'(WIDTH);
                            r_busy   <= 1'b1;
                            if (bus.ALUCtrl == 4'd7) begin
                                r_acc_lo <= w_mag_b;
                                r_opb    <= w_mag_a;
                                r_state  <= S_MUL;
                            end else begin
                                r_acc_lo <= w_mag_a;
                                r_opb    <= w_mag_b;
                                r_state  <= S_DIV;
                            end
                        end else if (bus.ALUCtrl == 4'd8) begin
                            // divide by zero: immediate, no iteration
                            r_lo     <= '1;
                            r_hi     <= bus.A;
                            r_result <= '1;
                            r_zero   <= 1'b0;
                            r_dbz    <= 1'b1;
                            r_done   <= 1'b1;
                        end else begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc_hi <= w_msum[WIDTH:1];
                    r_acc_lo <= {w_msum[0], r_acc_lo[WIDTH-1:1]};
                    r_cnt    <= r_cnt - c_CW'(1);
                    if (r_cnt == c_CW'(1)) r_state <= S_FIX;
                end
                S_DIV: begin
                    r_acc_hi <= w_dge ? w_ddiff : w_dshift[WIDTH-1:0];
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_dge};
                    r_cnt    <= r_cnt - c_CW'(1);
                    if (r_cnt == c_CW'(1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi     <= w_fix_hi;
                    r_lo     <= w_fix_lo;
                    r_result <= w_fix_lo;
                    r_zero   <= (w_fix_lo == '0);
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.busy        = r_busy;
    assign bus.div_by_zero = r_dbz;
`else
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= bus.start;
            if (bus.start) begin
                r_result <= w_alu;
                r_zero   <= (w_alu == '0);
            end
        end
    end

    assign bus.hi          = '0;
    assign bus.lo          = '0;
    assign bus.busy        = 1'b0;
    assign bus.div_by_zero = 1'b0;
`endif

    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.done   = r_done;
endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec
//  Description : Self-checking bench for alu_exec (WIDTH=32). Table of
//                single-cycle vectors plus hand-written mult/div, busy,
//                back-to-back and reset-abort sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_exec_if #(.WIDTH(WIDTH)) bus ();

    alu_exec #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call right after a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        bus.ALUCtrl = code;
        bus.A       = a;
        bus.B       = b;
        bus.shamt   = sh;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Waits for busy to drop; returns number of negedges busy was seen high.
    task automatic wait_idle(output int n, output logic early_done);
        n = 0;
        early_done = 1'b0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (bus.done === 1'b1) early_done = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int   n;
        logic ed;
        logic seen_done;

        checks = 0;
        errors = 0;
        bus.start   = 1'b0;
        bus.ALUCtrl = 4'd0;
        bus.A       = '0;
        bus.B       = '0;
        bus.shamt   = '0;

        vecs[0]  = '{4'd2,  32'd7,         32'd5,         5'd0,  32'd12,        1'b0};
        vecs[1]  = '{4'd3,  32'd5,         32'd5,         5'd0,  32'd0,         1'b1};
        vecs[2]  = '{4'd0,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0,  32'h00F0_000F, 1'b0};
        vecs[3]  = '{4'd1,  32'hF000_0000, 32'h0000_000A, 5'd0,  32'hF000_000A, 1'b0};
        vecs[4]  = '{4'd4,  32'hFFFF_FFFF, 32'd0,         5'd0,  32'd1,         1'b0};
        vecs[5]  = '{4'd4,  32'd5,         32'hFFFF_FFFD, 5'd0,  32'd0,         1'b1};
        vecs[6]  = '{4'd5,  32'd5,         32'hFFFF_FFFD, 5'd0,  32'd1,         1'b0};
        vecs[7]  = '{4'd5,  32'h8000_0000, 32'd0,         5'd0,  32'd0,         1'b1};
        vecs[8]  = '{4'd6,  32'h0000_FFFF, 32'd0,         5'd0,  32'hFFFF_0000, 1'b0};
        vecs[9]  = '{4'd9,  32'd0,         32'd1,         5'd31, 32'h8000_0000, 1'b0};
        vecs[10] = '{4'd10, 32'd0,         32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0};
        vecs[11] = '{4'd10, 32'd0,         32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[12] = '{4'd15, 32'd3,         32'd4,         5'd1,  32'd0,         1'b1};
        vecs[13] = '{4'd11, 32'hFFFF_FFFF, 32'd9,         5'd2,  32'd0,         1'b1};
        vecs[14] = '{4'd2,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b1};
        vecs[15] = '{4'd3,  32'd0,         32'd1,         5'd0,  32'hFFFF_FFFF, 1'b0};

        // reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_result", {32'd0, bus.result}, 64'd0);
        chk("rst_zero",   {63'd0, bus.zero}, 64'd0);
        chk("rst_done",   {63'd0, bus.done}, 64'd0);
        chk("rst_busy",   {63'd0, bus.busy}, 64'd0);
        chk("rst_hilo",   {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].sh);
            chk($sformatf("v%0d_result", i), {32'd0, bus.result}, {32'd0, vecs[i].exp_res});
            chk($sformatf("v%0d_zero", i),   {63'd0, bus.zero},   {63'd0, vecs[i].exp_zero});
            chk($sformatf("v%0d_done", i),   {63'd0, bus.done},   64'd1);
            @(negedge clk);
            chk($sformatf("v%0d_done_low", i), {63'd0, bus.done}, 64'd0);
        end

        // back-to-back with start held
        bus.ALUCtrl = 4'd2; bus.A = 32'd1; bus.B = 32'd2; bus.start = 1'b1;
        @(negedge clk);
        chk("b2b_res0",  {32'd0, bus.result}, 64'd3);
        chk("b2b_done0", {63'd0, bus.done}, 64'd1);
        bus.ALUCtrl = 4'd1; bus.A = 32'd4; bus.B = 32'd8;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_res1",  {32'd0, bus.result}, 64'd12);
        chk("b2b_done1", {63'd0, bus.done}, 64'd1);
        @(negedge clk);

`ifdef ALU_MULDIV_EN
        // mult -3 * 7 with an ignored start mid-operation
        issue(4'd7, 32'hFFFF_FFFD, 32'd7, 5'd0);
        chk("mul_busy0", {63'd0, bus.busy}, 64'd1);
        repeat (5) @(negedge clk);
        issue(4'd2, 32'd1, 32'd1, 5'd0);
        wait_idle(n, ed);
        chk("mul_busy_cycles", n + 6, 33);
        chk("mul_no_early_done", {63'd0, ed}, 64'd0);
        chk("mul_done", {63'd0, bus.done}, 64'd1);
        chk("mul_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_result", {32'd0, bus.result}, 64'hFFFF_FFEB);
        chk("mul_zero", {63'd0, bus.zero}, 64'd0);
        @(negedge clk);
        chk("mul_done_low", {63'd0, bus.done}, 64'd0);

        // illegal code leaves hi/lo alone
        issue(4'd15, 32'd1, 32'd1, 5'd0);
        chk("ill_result", {32'd0, bus.result}, 64'd0);
        chk("ill_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);

        // div -7 / 2
        issue(4'd8, 32'hFFFF_FFF9, 32'd2, 5'd0);
        wait_idle(n, ed);
        chk("div1_cycles", n, 33);
        chk("div1_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div1_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        @(negedge clk);

        // div 100 / -7
        issue(4'd8, 32'd100, 32'hFFFF_FFF9, 5'd0);
        wait_idle(n, ed);
        chk("div2_hilo", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFF2);
        @(negedge clk);

        // most-negative / -1
        issue(4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        wait_idle(n, ed);
        chk("div3_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        @(negedge clk);

        // 9 / 0
        issue(4'd8, 32'd9, 32'd0, 5'd0);
        chk("dbz_done", {63'd0, bus.done}, 64'd1);
        chk("dbz_busy", {63'd0, bus.busy}, 64'd0);
        chk("dbz_hilo", {bus.hi, bus.lo}, 64'h0000_0009_FFFF_FFFF);
        chk("dbz_result", {32'd0, bus.result}, 64'hFFFF_FFFF);
        chk("dbz_flag", {63'd0, bus.div_by_zero}, 64'd1);
        repeat (2) @(negedge clk);
        chk("dbz_sticky", {63'd0, bus.div_by_zero}, 64'd1);
        issue(4'd2, 32'd1, 32'd1, 5'd0);
        chk("dbz_cleared", {63'd0, bus.div_by_zero}, 64'd0);
        @(negedge clk);

        // reset mid-mult
        issue(4'd7, 32'hFFFF_FFFD, 32'd7, 5'd0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_result", {32'd0, bus.result}, 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_zero", {63'd0, bus.zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
        end
        chk("abort_no_done", {63'd0, seen_done}, 64'd0);
        issue(4'd2, 32'd2, 32'd2, 5'd0);
        chk("post_abort_add", {32'd0, bus.result}, 64'd4);
`else
        // mult/div not built: codes 7/8 act as illegal codes
        issue(4'd7, 32'hFFFF_FFFD, 32'd7, 5'd0);
        chk("nomul_result", {32'd0, bus.result}, 64'd0);
        chk("nomul_zero", {63'd0, bus.zero}, 64'd1);
        chk("nomul_done", {63'd0, bus.done}, 64'd1);
        chk("nomul_busy", {63'd0, bus.busy}, 64'd0);
        chk("nomul_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        issue(4'd2, 32'd6, 32'd6, 5'd0);
        chk("pre_div_result", {32'd0, bus.result}, 64'd12);
        @(negedge clk);
        issue(4'd8, 32'd9, 32'd0, 5'd0);
        chk("nodiv_result", {32'd0, bus.result}, 64'd0);
        chk("nodiv_done", {63'd0, bus.done}, 64'd1);
        chk("nodiv_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        chk("nodiv_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);

        // reset while results are held
        issue(4'd2, 32'd7, 32'd5, 5'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_result", {32'd0, bus.result}, 64'd0);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        chk("abort_no_done", {63'd0, seen_done}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU that consumes the 4-bit `ALUCtrl` code from ALU control and produces the registered result, zero flag and HI/LO pair. Single-cycle ops (logic, add/sub, compares, not, shifts) complete in one clock. `mult` and `div` run on an iterative 1-bit-per-cycle datapath and hold off the pipeline with `busy`. The block sits between ALU control / register read and the memory/writeback stage.

## Interface
- `WIDTH`, 32, operand and result width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; sampled only when `busy`=0.
- `ALUCtrl`  in  4  operation code from ALU control.
- `A`  in  WIDTH  operand rs.
- `B`  in  WIDTH  operand rt, or immediate.
- `shamt`  in  5  shift amount; only the low log2(WIDTH) bits are used.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  registered (`result`==0).
- `hi`, `lo`  out  WIDTH  mult/div result registers.
- `busy`  out  1  multicycle op in progress; new `start` ignored.
- `done`  out  1  one-cycle pulse: `result`/`zero`/`hi`/`lo` updated.
- `div_by_zero`  out  1  sticky until next accepted `start`; set by div with `B`=0.

## Operation
- **Codes:**
  - 0 `A&B`; 1 `A|B`; 2 `A+B`; 3 `A-B` (all mod 2^WIDTH).
  - 4 result=1 if signed `A<B`, else 0.
  - 5 result=1 if signed `A>B`, else 0.
  - 6 `~A`.
  - 7 signed mult.
  - 8 signed div.
  - 9 `B<<shamt`; 10 `B>>shamt` (logical).
  - 11–15: result=0, `hi`/`lo` unchanged.
- **FSM states:** IDLE, MUL, DIV, FIX.
  - IDLE: accepted `start` with a single-cycle code → registers loaded at that edge, `done`=1 next cycle, stay IDLE.
  - IDLE: accepted code 7 or 8 → magnitudes of `A`/`B` and result sign latched, counter=WIDTH, go MUL or DIV, `busy`=1.
  - MUL: shift-add one bit per cycle, counter decrements; at 0 go FIX.
  - DIV: restoring subtract one bit per cycle; at 0 go FIX.
  - FIX: apply sign, load `hi`/`lo`/`result`, go IDLE, `busy`=0, `done`=1 next cycle.
- **Mult:** full 2·WIDTH signed product; `hi` = upper half, `lo` = lower half, `result`=`lo`.
- **Div:** quotient truncated toward zero → `lo` and `result`; remainder takes the dividend's sign → `hi`.
- **Div, `B`=0:** no iteration. At the accept edge `lo`=all ones, `hi`=`A`, `result`=all ones, `div_by_zero`=1, `done` next cycle.
- **Div, most-negative ÷ −1:** `lo` = most-negative value (wraps), `hi`=0.
- **`start` while `busy`=1:** ignored; no state change.
- **Reset values:** all outputs 0; FSM IDLE; counter 0.

## Timing
- **Single-cycle op:** accepted at edge k → `done` high for cycle k..k+1. `start` may be held every cycle for back-to-back ops.
- **Mult/div:**
  - accepted at edge k; `busy` high from k.
  - WIDTH iteration edges (k+1..k+WIDTH), then FIX at edge k+WIDTH+1.
  - `busy` falls and `done` rises at edge k+WIDTH+1.
  - Next `start` accepted at edge k+WIDTH+2 at earliest.
- **Outputs hold between operations:** `result`, `zero`, `hi`, `lo` hold their last values until the next `done`.
- **Reset mid-operation:** `rst_n` low aborts immediately and asynchronously; no `done` is produced. After release the block is IDLE.

## Configuration
- **`ALU_MULDIV_EN` defined:** mult/div hardware and the MUL/DIV/FIX states are built, as described above.
- **`ALU_MULDIV_EN` not defined:**
  - codes 7 and 8 behave as illegal codes (result=0, single-cycle `done`);
  - `hi`, `lo`, `busy` and `div_by_zero` are tied to 0;
  - no iterative logic is synthesized.

## Test plan
- **Add:** `A`=7, `B`=5, code 2 → next cycle `result`=12, `zero`=0, `done`=1 for exactly one cycle. Then code 3 with 5−5 → `result`=0, `zero`=1.
- **Mult:** `A`=−3, `B`=7, code 7 → `busy`=1 for 33 cycles, `done` at edge 33. `lo`=0xFFFFFFEB, `hi`=0xFFFFFFFF, `result`=0xFFFFFFEB.
- **Div:** `A`=−7, `B`=2, code 8 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then `A`=9, `B`=0 → `done` next cycle, `lo`=0xFFFFFFFF, `hi`=9, `div_by_zero`=1.
- **Shifts and compares:**
  - code 9, `B`=1, `shamt`=31 → 0x80000000.
  - code 10, `B`=0x80000000, `shamt`=4 → 0x08000000.
  - code 4, `A`=−1, `B`=0 → 1.
  - code 15 → 0.
- **Start while busy:** pulse code 2 `start` mid-mult → ignored, mult result unchanged.
- **Reset mid-mult:** assert `rst_n`=0 at iteration 10 → all outputs 0 immediately, no `done` after release.
